// File: rtl/music_pkg.sv
// music_pkg: note codes, sequencer state encoding and default tempo divider.
package music_pkg;
   localparam int TICK_DIV_DEF = 1_000_000;
   localparam logic [7:0] REST   = 8'd0;
   localparam logic [7:0] NOTE_G = 8'd23;
   localparam logic [7:0] NOTE_A = 8'd25;
   localparam logic [7:0] NOTE_B = 8'd27;
   localparam logic [7:0] NOTE_C = 8'd28;
   localparam logic [7:0] NOTE_D = 8'd30;
   typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;
endpackage

// File: rtl/music_sequencer_if.sv
// music_sequencer_if: control inputs from the game FSM and note outputs to the tone generator.
interface music_sequencer_if #(
   parameter int ADDR_W  = 8,
   parameter int NOTE_W  = 8,
   parameter int SCALE_W = 3
) ();
   logic               start;
   logic               pause;
   logic               stop;
   logic               loop_en;
   logic [SCALE_W-1:0] tempo_scale;
   logic [NOTE_W-1:0]  note;
   logic               note_on;
   logic [ADDR_W-1:0]  step_addr;
   logic               playing;
   logic               done;
   modport master (output start, pause, stop, loop_en, tempo_scale,
                   input note, note_on, step_addr, playing, done);
   modport slave  (input start, pause, stop, loop_en, tempo_scale,
                   output note, note_on, step_addr, playing, done);
endinterface

// File: rtl/music_sequencer_rom.sv
// song_rom: synchronous note table; addresses at or beyond SONG_LEN read as rest.
module song_rom
   import music_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int NOTE_W   = 8,
   parameter int SONG_LEN = 201
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic [NOTE_W-1:0] note
);
   logic [NOTE_W-1:0] data;
   always_comb begin
      case (addr)
         ADDR_W'(0): data = NOTE_W'(NOTE_B);
         ADDR_W'(1): data = NOTE_W'(NOTE_B);
         ADDR_W'(3): data = NOTE_W'(NOTE_D);
         ADDR_W'(4): data = NOTE_W'(NOTE_D);
         ADDR_W'(5): data = NOTE_W'(NOTE_D);
         ADDR_W'(7): data = NOTE_W'(NOTE_G);
         default:    data = NOTE_W'(REST);
      endcase
   end
   always_ff @(posedge clk)
      note <= (int'(addr) < SONG_LEN) ? data : '0;
endmodule

// File: rtl/music_sequencer.sv
// music_sequencer: steps the song table at a programmable tempo with play/pause/stop/loop control.
module music_sequencer
   import music_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int ADDR_W   = 8,
   parameter int NOTE_W   = 8,
   parameter int SONG_LEN = 201,
   parameter int SCALE_W  = 3
) (
   input logic clk,
   input logic rst_n,
   music_sequencer_if.slave bus
);
   localparam int TW = $clog2(TICK_DIV + 1);
   localparam logic [TW-1:0]     TICK_MAX = TW'(TICK_DIV - 1);
   localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(SONG_LEN - 1);
   state_t             state;
   logic [TW-1:0]      tick;
   logic [SCALE_W-1:0] scale;
   logic [ADDR_W-1:0]  addr;
   logic [NOTE_W-1:0]  rom_note;
   logic [NOTE_W-1:0]  prev;
   logic               en;
   logic               done_q;
   logic               wrap;
   logic               step;
   logic               last;
   song_rom #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .SONG_LEN(SONG_LEN)) u_rom (
      .clk (clk),
      .addr(addr),
      .note(rom_note)
   );
   // >= lets a lowered tempo_scale end an overlong step at the next wrap
   always_comb begin
      wrap = tick == TICK_MAX;
      step = wrap && scale >= bus.tempo_scale;
      last = addr == LAST;
   end
   // every path into IDLE clears the counters, so PLAY always starts fresh from IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         tick   <= '0;
         scale  <= '0;
         addr   <= '0;
         en     <= 1'b0;
         prev   <= '0;
         done_q <= 1'b0;
      end else begin
         en     <= state == PLAY;
         prev   <= bus.note;
         done_q <= 1'b0;
         if (bus.stop) begin
            state <= IDLE;
            tick  <= '0;
            scale <= '0;
            addr  <= '0;
         end else begin
            case (state)
               IDLE: if (bus.start && !bus.pause) state <= PLAY;
               PLAY: begin
                  tick  <= wrap ? '0 : tick + 1'b1;
                  scale <= step ? '0 : wrap ? scale + 1'b1 : scale;
                  if (step && last && !bus.loop_en) begin
                     state  <= IDLE;
                     addr   <= '0;
                     done_q <= 1'b1;
                  end else begin
                     if (step) addr <= last ? '0 : addr + 1'b1;
                     if (bus.pause) state <= PAUSE;
                  end
               end
               PAUSE: if (!bus.pause && bus.start) state <= PLAY;
               default: state <= IDLE;
            endcase
         end
      end
   end
   assign bus.note      = en ? rom_note : '0;
   assign bus.note_on   = (bus.note != '0) && (bus.note != prev);
   assign bus.step_addr = addr;
   assign bus.playing   = state == PLAY;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: directed checks of reset, tempo, loop, pause and stop behaviour.
module tb_music_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int total = 0;
   int bad = 0;
   int ons;
   int dones;
   logic [7:0] tbl [8] = '{8'd27, 8'd27, 8'd0, 8'd30, 8'd30, 8'd30, 8'd0, 8'd23};
   always #5 clk = ~clk;
   music_sequencer_if bus ();
   music_sequencer #(.TICK_DIV(4), .SONG_LEN(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic halt();
      @(negedge clk) bus.stop = 1'b1;
      @(negedge clk) bus.stop = 1'b0;
      check("halt_play", bus.playing, 0);
      check("halt_addr", bus.step_addr, 0);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.stop = 1'b0;
      bus.loop_en = 1'b0;
      bus.tempo_scale = 3'd0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_addr", bus.step_addr, 0);
      check("rst_note", bus.note, 0);
      check("rst_on", bus.note_on, 0);
      check("rst_play", bus.playing, 0);
      check("rst_done", bus.done, 0);
      rst_n = 1'b1;
      // reset while step 3 is sounding
      @(negedge clk) bus.start = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      check("pre_rst_addr", bus.step_addr, 3);
      check("pre_rst_note", bus.note, 30);
      #2 rst_n = 1'b0;
      #1;
      check("arst_addr", bus.step_addr, 0);
      check("arst_note", bus.note, 0);
      check("arst_on", bus.note_on, 0);
      check("arst_play", bus.playing, 0);
      check("arst_done", bus.done, 0);
      @(negedge clk) rst_n = 1'b1;
      // full song, tempo_scale 0, no loop
      ons = 0;
      dones = 0;
      @(negedge clk) bus.start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         ons += int'(bus.note_on);
         dones += int'(bus.done);
         check("t1_addr", bus.step_addr, c <= 32 ? (c - 1) / 4 : 0);
         check("t1_note", bus.note, (c >= 2 && c <= 33) ? 32'(tbl[(c - 2) / 4]) : 0);
         check("t1_play", bus.playing, c <= 32 ? 1 : 0);
         if (c == 33) check("t1_done", bus.done, 1);
      end
      check("t1_ons", ons, 3);
      check("t1_dones", dones, 1);
      // looping at tempo_scale 1
      bus.loop_en = 1'b1;
      bus.tempo_scale = 3'd1;
      ons = 0;
      dones = 0;
      @(negedge clk) bus.start = 1'b1;
      for (int c = 1; c <= 72; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         ons += int'(bus.note_on);
         dones += int'(bus.done);
         check("t2_addr", bus.step_addr, ((c - 1) / 8) % 8);
         if (c == 66) check("t2_wrap_on", bus.note_on, 1);
      end
      check("t2_ons", ons, 4);
      check("t2_dones", dones, 0);
      halt();
      bus.loop_en = 1'b0;
      bus.tempo_scale = 3'd0;
      // pause two cycles into step 3 for ten cycles
      @(negedge clk) bus.start = 1'b1;
      for (int c = 1; c <= 28; c++) begin
         @(negedge clk);
         bus.start = c == 24;
         bus.pause = c >= 14 && c < 24;
         check("t3_addr", bus.step_addr, c < 13 ? (c - 1) / 4 : c < 27 ? 3 : 4);
         check("t3_play", bus.playing, (c >= 15 && c <= 24) ? 0 : 1);
         if (c == 20) check("t3_mute", bus.note, 0);
         if (c == 26) check("t3_note", bus.note, 30);
         if (c == 26) check("t3_on", bus.note_on, 1);
      end
      halt();
      // stop and start together, then restart
      dones = 0;
      @(negedge clk) bus.start = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         bus.start = c == 10 || c == 11;
         bus.stop = c == 10;
         dones += int'(bus.done);
         if (c == 10) check("t4_addr_pre", bus.step_addr, 2);
         if (c == 11) check("t4_stop_addr", bus.step_addr, 0);
         if (c == 11) check("t4_stop_play", bus.playing, 0);
         if (c == 12) check("t4_restart", bus.playing, 1);
         if (c == 13) check("t4_note", bus.note, 27);
         if (c == 13) check("t4_on", bus.note_on, 1);
         if (c == 16) check("t4_addr", bus.step_addr, 1);
      end
      check("t4_dones", dones, 0);
      halt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
